// File: rtl/mem_stage_ext_if.sv
// EX/MEM -> MEM/WB bus of the parametrised MEM stage.
// Master drives the EX/MEM side; slave is the MEM stage itself.
// The stall output is the only backpressure on this bus.
interface mem_stage_ext_if #(
    parameter int DATA_W = 32,
    parameter int WB_W   = 2,
    parameter int REG_W  = 5
);
    logic [WB_W-1:0]   wb_MEM;
    logic [REG_W-1:0]  reg_MEM;
    logic              branch;
    logic              mem_read;
    logic              mem_write;
    logic [1:0]        size;
    logic              ld_unsigned;
    logic              zero;
    logic [DATA_W-1:0] address_MEM;
    logic [DATA_W-1:0] write_data_mem;

    logic [WB_W-1:0]   wb;
    logic [REG_W-1:0]  reg_WB;
    logic [DATA_W-1:0] address_WB;
    logic [DATA_W-1:0] read_data;
    logic              PCSrc;
    logic              stall;
    logic              misaligned;

    modport master (
        output wb_MEM, reg_MEM, branch, mem_read, mem_write, size, ld_unsigned,
               zero, address_MEM, write_data_mem,
        input  wb, reg_WB, address_WB, read_data, PCSrc, stall, misaligned
    );

    modport slave (
        input  wb_MEM, reg_MEM, branch, mem_read, mem_write, size, ld_unsigned,
               zero, address_MEM, write_data_mem,
        output wb, reg_WB, address_WB, read_data, PCSrc, stall, misaligned
    );
endinterface

// File: rtl/mem_stage_ext.sv
// MIPS MEM stage: byte/half/word loads+stores with extension, misalignment flag.
// Latency: WAIT+1 cycles for aligned memory ops, 1 cycle otherwise.
// Backpressure: combinational stall holds upstream while the access is in wait states.
module mem_stage_ext #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int WB_W   = 2,
    parameter int REG_W  = 5,
    parameter int WAIT   = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_stage_ext_if.slave bus
);
    localparam int         AW     = $clog2(DEPTH);
    localparam logic [3:0] WAIT_C = 4'(WAIT);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic [AW-1:0]     idx;
    logic [1:0]        lane;
    logic              mem_op;
    logic              misal;
    logic              acc_ok;
    logic              is_load;
    logic              we;
    logic [3:0]        be;
    logic [DATA_W-1:0] wmask;
    logic [DATA_W-1:0] wdat;
    logic [DATA_W-1:0] rword;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] ld_val;
    logic [DATA_W-1:0] words [DEPTH];
    logic              unused_addr;

    // Address bits above the memory span are dropped, so accesses alias.
    assign idx         = bus.address_MEM[AW+1:2];
    assign lane        = bus.address_MEM[1:0];
    assign unused_addr = ^bus.address_MEM[DATA_W-1:AW+2];

    assign mem_op  = bus.mem_read | bus.mem_write;
    assign misal   = mem_op & (((bus.size == 2'b01) & lane[0]) | (bus.size[1] & (lane != 2'b00)));
    assign acc_ok  = mem_op & ~misal;
    assign is_load = bus.mem_read & ~bus.mem_write & acc_ok;

    assign bus.PCSrc = bus.branch & bus.zero;
    assign bus.stall = acc_ok & (WAIT_C != 4'd0) & ((state == IDLE) | (cnt < WAIT_C));

    // Stores commit only on the completing edge and never during reset.
    assign we = rst_n & ~bus.stall & bus.mem_write & acc_ok;

    always_comb begin
        be    = 4'b1111;
        wdat  = bus.write_data_mem;
        wmask = '0;
        case (bus.size)
            2'b00: begin
                be   = 4'b0001 << lane;
                wdat = {4{bus.write_data_mem[7:0]}};
            end
            2'b01: begin
                be   = lane[1] ? 4'b1100 : 4'b0011;
                wdat = {2{bus.write_data_mem[15:0]}};
            end
            default: ;
        endcase
        for (int k = 0; k < 4; k++) wmask[8*k +: 8] = {8{be[k]}};
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        logic [DATA_W-1:0] word_q = DATA_W'(g);
        always_ff @(posedge clk) begin
            if (we && (idx == AW'(g))) word_q <= (word_q & ~wmask) | (wdat & wmask);
        end
        assign words[g] = word_q;
    end

    assign rword = words[idx];

    always_comb begin
        case (lane)
            2'd0:    ld_byte = rword[7:0];
            2'd1:    ld_byte = rword[15:8];
            2'd2:    ld_byte = rword[23:16];
            default: ld_byte = rword[31:24];
        endcase
        ld_half = lane[1] ? rword[31:16] : rword[15:0];
        case (bus.size)
            2'b00:   ld_val = {{24{~bus.ld_unsigned & ld_byte[7]}}, ld_byte};
            2'b01:   ld_val = {{16{~bus.ld_unsigned & ld_half[15]}}, ld_half};
            default: ld_val = rword;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            bus.wb         <= {WB_W{1'b0}};
            bus.reg_WB     <= {REG_W{1'b0}};
            bus.address_WB <= '0;
            bus.read_data  <= '0;
            bus.misaligned <= 1'b0;
        end else if (bus.stall) begin
            // Wait state: bubble into WB, remaining MEM/WB fields hold.
            state      <= BUSY;
            cnt        <= cnt + 4'd1;
            bus.wb     <= {WB_W{1'b0}};
            bus.reg_WB <= {REG_W{1'b0}};
        end else begin
            state          <= IDLE;
            cnt            <= 4'd0;
            bus.wb         <= misal ? {WB_W{1'b0}} : bus.wb_MEM;
            bus.reg_WB     <= bus.reg_MEM;
            bus.address_WB <= bus.address_MEM;
            bus.read_data  <= is_load ? ld_val : '0;
            bus.misaligned <= misal;
        end
    end
endmodule

// File: tb/tb_mem_stage_ext.sv
// Directed + random bench for mem_stage_ext against a byte-addressed memory model.
module tb_mem_stage_ext;
    localparam int WAIT0 = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] bm [1024];

    always #5 clk = ~clk;

    mem_stage_ext_if #(.DATA_W(32), .WB_W(2), .REG_W(5)) b0 ();
    mem_stage_ext_if #(.DATA_W(32), .WB_W(2), .REG_W(5)) b1 ();

    mem_stage_ext #(.DATA_W(32), .DEPTH(256), .WB_W(2), .REG_W(5), .WAIT(WAIT0))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    mem_stage_ext #(.DATA_W(32), .DEPTH(256), .WB_W(2), .REG_W(5), .WAIT(0))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle0();
        b0.wb_MEM = 0; b0.reg_MEM = 0; b0.branch = 0; b0.mem_read = 0; b0.mem_write = 0;
        b0.size = 0; b0.ld_unsigned = 0; b0.zero = 0; b0.address_MEM = 0; b0.write_data_mem = 0;
    endtask

    task automatic idle1();
        b1.wb_MEM = 0; b1.reg_MEM = 0; b1.branch = 0; b1.mem_read = 0; b1.mem_write = 0;
        b1.size = 0; b1.ld_unsigned = 0; b1.zero = 0; b1.address_MEM = 0; b1.write_data_mem = 0;
    endtask

    // One full transaction on dut0, checked against the byte-array model.
    task automatic op(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                      input logic uns, input logic [31:0] a, input logic [31:0] wd,
                      input logic [1:0] wbv, input logic [4:0] rg, input logic br, input logic zr);
        int n, b, nst, exp_st;
        bit mis;
        logic [31:0] v;
        n   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        mis = (rd || wr) && ((a % n) != 0);
        b0.mem_read = rd; b0.mem_write = wr; b0.size = sz; b0.ld_unsigned = uns;
        b0.address_MEM = a; b0.write_data_mem = wd; b0.wb_MEM = wbv; b0.reg_MEM = rg;
        b0.branch = br; b0.zero = zr;
        #1;
        chk({tag, ".pcsrc"}, 32'(b0.PCSrc), 32'(br & zr));
        nst = 0;
        while (b0.stall === 1'b1 && nst < 20) begin
            @(posedge clk); #1;
            nst++;
            if (nst == 1) chk({tag, ".bubble_wb"}, 32'(b0.wb), 32'd0);
        end
        exp_st = ((rd || wr) && !mis) ? WAIT0 : 0;
        chk({tag, ".stall_cycles"}, 32'(nst), 32'(exp_st));
        @(posedge clk); #1;
        v = 0;
        b = int'(a % 1024);
        if (!mis) begin
            if (wr) begin
                for (int k = 0; k < n; k++) bm[b+k] = 8'(wd >> (8*k));
            end else if (rd) begin
                for (int k = 0; k < n; k++) v |= 32'(bm[b+k]) << (8*k);
                if (!uns && n < 4 && v[8*n-1]) v |= ~((32'd1 << (8*n)) - 32'd1);
            end
        end
        chk({tag, ".wb"}, 32'(b0.wb), mis ? 32'd0 : 32'(wbv));
        chk({tag, ".reg_WB"}, 32'(b0.reg_WB), 32'(rg));
        chk({tag, ".address_WB"}, b0.address_WB, a);
        chk({tag, ".misaligned"}, 32'(b0.misaligned), 32'(mis));
        if (rd || mis) chk({tag, ".read_data"}, b0.read_data, v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        for (int i = 0; i < 256; i++)
            for (int k = 0; k < 4; k++) bm[4*i+k] = 8'(i >> (8*k));
        idle0(); idle1();

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.wb", 32'(b0.wb), 0);
        chk("rst.reg_WB", 32'(b0.reg_WB), 0);
        chk("rst.address_WB", b0.address_WB, 0);
        chk("rst.read_data", b0.read_data, 0);
        chk("rst.misaligned", 32'(b0.misaligned), 0);
        chk("rst.stall", 32'(b0.stall), 0);
        rst_n = 1'b1;

        op("lw_0c", 1, 0, 2'b10, 0, 32'h0C, 0, 2'b11, 5'd7, 0, 0);
        chk("lw_0c.value", b0.read_data, 32'h3);

        op("sw_10", 0, 1, 2'b10, 0, 32'h10, 32'h8081F2F3, 2'b01, 5'd1, 0, 0);
        op("lb_10", 1, 0, 2'b00, 0, 32'h10, 0, 2'b01, 5'd2, 0, 0);
        chk("lb_10.value", b0.read_data, 32'hFFFFFFF3);
        op("lbu_11", 1, 0, 2'b00, 1, 32'h11, 0, 2'b01, 5'd3, 0, 0);
        chk("lbu_11.value", b0.read_data, 32'h000000F2);
        op("lh_12", 1, 0, 2'b01, 0, 32'h12, 0, 2'b01, 5'd4, 1, 1);
        chk("lh_12.value", b0.read_data, 32'hFFFF8081);
        op("lhu_12", 1, 0, 2'b01, 1, 32'h12, 0, 2'b01, 5'd5, 1, 0);
        chk("lhu_12.value", b0.read_data, 32'h00008081);

        op("sb_13", 0, 1, 2'b00, 0, 32'h13, 32'h123456AA, 2'b10, 5'd6, 0, 0);
        op("lw_10a", 1, 0, 2'b10, 0, 32'h10, 0, 2'b10, 5'd7, 0, 0);
        chk("lw_10a.value", b0.read_data, 32'hAA81F2F3);
        op("sh_10", 0, 1, 2'b01, 0, 32'h10, 32'h0000BEEF, 2'b10, 5'd8, 0, 0);
        op("lw_10b", 1, 0, 2'b10, 0, 32'h10, 0, 2'b10, 5'd9, 0, 0);
        chk("lw_10b.value", b0.read_data, 32'hAA81BEEF);

        op("lw_06_mis", 1, 0, 2'b10, 0, 32'h06, 0, 2'b11, 5'd10, 0, 0);
        op("sh_05_mis", 0, 1, 2'b01, 0, 32'h05, 32'hFFFF, 2'b11, 5'd11, 0, 0);
        op("lw_04", 1, 0, 2'b10, 0, 32'h04, 0, 2'b11, 5'd12, 0, 0);
        chk("lw_04.value", b0.read_data, 32'h1);

        op("lw_400", 1, 0, 2'b10, 0, 32'h400, 0, 2'b01, 5'd13, 0, 0);
        chk("lw_400.value", b0.read_data, 32'h0);

        // Reset pulse while a store sits in its wait states: store must be dropped.
        b0.mem_read = 0; b0.mem_write = 1; b0.size = 2'b10; b0.address_MEM = 32'h20;
        b0.write_data_mem = 32'hDEADBEEF; b0.wb_MEM = 2'b11; b0.reg_MEM = 5'd14;
        @(posedge clk); #1;
        chk("abort.busy_stall", 32'(b0.stall), 1);
        rst_n = 1'b0;
        idle0();
        @(posedge clk); #1;
        chk("abort.stall", 32'(b0.stall), 0);
        chk("abort.wb", 32'(b0.wb), 0);
        rst_n = 1'b1;
        op("lw_20", 1, 0, 2'b10, 0, 32'h20, 0, 2'b01, 5'd15, 0, 0);
        chk("lw_20.value", b0.read_data, 32'h8);

        for (int i = 0; i < 40; i++) begin
            a = 32'($urandom_range(0, 2047));
            if ($urandom_range(0, 1) == 0) a = a & ~32'd3;
            op("rand", 1'($urandom), 1'($urandom_range(0, 3) == 0), 2'($urandom), 1'($urandom),
               a, $urandom, 2'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
        end
        idle0();

        b1.branch = 1; b1.zero = 1;
        #1;
        chk("w0.pcsrc", 32'(b1.PCSrc), 1);
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b1.address_MEM = a;
            b1.branch = 1'($urandom); b1.zero = 1'($urandom);
            #1;
            chk("w0.pcsrc_r", 32'(b1.PCSrc), 32'(b1.branch & b1.zero));
            chk("w0.stall", 32'(b1.stall), 0);
            @(posedge clk); #1;
            chk("w0.address_WB", b1.address_WB, a);
        end
        idle1();
        b1.mem_read = 1; b1.size = 2'b10; b1.address_MEM = 32'h0C; b1.wb_MEM = 2'b10;
        #1;
        chk("w0.lw_stall", 32'(b1.stall), 0);
        @(posedge clk); #1;
        chk("w0.lw_value", b1.read_data, 32'h3);
        chk("w0.lw_wb", 32'(b1.wb), 32'h2);
        idle1();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
